// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: CPU-side command/response bus of the RAM access controller.
// Signals: cmd_valid/cmd_ready handshake, cmd_write, cmd_size, cmd_signed, cmd_addr (byte address),
//   cmd_wdata (right-aligned store data); rsp_valid pulse, rsp_rdata, rsp_error.
// Modports: master = requester (CPU/bus side), slave = controller.
interface ram_access_ctrl_if #(
   parameter int ADDRESS_BITWIDTH = 16
);
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic                        cmd_write;
   logic [1:0]                  cmd_size;
   logic                        cmd_signed;
   logic [ADDRESS_BITWIDTH+1:0] cmd_addr;
   logic [31:0]                 cmd_wdata;
   logic                        rsp_valid;
   logic [31:0]                 rsp_rdata;
   logic                        rsp_error;
   modport master (
      output cmd_valid, cmd_write, cmd_size, cmd_signed, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
   );
   modport slave (
      input  cmd_valid, cmd_write, cmd_size, cmd_signed, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: byte-addressed load/store front end for a single-port 32-bit block RAM.
// Ports: clk; rst_n (synchronous, active low); bus (ram_access_ctrl_if.slave, command/response);
//   ram_write_enable, ram_address, ram_data_in to the RAM; ram_data_out from the RAM (1-cycle read).
// Sub-word stores are read-modify-write: the RAM reads the old word at the accept edge and the
//   merged word is written back in the single ACCESS cycle. Loads are zero/sign extended.
// Optional: define RAM_ACCESS_ALIGN_CHECK_EN to report misaligned or reserved-size commands on rsp_error.
module ram_access_ctrl #(
   parameter int ADDRESS_BITWIDTH = 16,
   parameter int DATA_BITWIDTH    = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   ram_access_ctrl_if.slave            bus,
   output logic                        ram_write_enable,
   output logic [ADDRESS_BITWIDTH-1:0] ram_address,
   output logic [DATA_BITWIDTH-1:0]    ram_data_in,
   input  logic [DATA_BITWIDTH-1:0]    ram_data_out
);
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;
   logic [0:0]                  state;
   logic                        wr, sgn, err;
   logic [1:0]                  sz, lo;
   logic [ADDRESS_BITWIDTH-1:0] wa;
   logic [DATA_BITWIDTH-1:0]    wd, mask, rep, ld;
   logic [4:0]                  sh;
   logic [15:0]                 lane;
`ifdef RAM_ACCESS_ALIGN_CHECK_EN
   assign err = (sz == 2'b11) | (sz == 2'b01 & lo[0]) | (sz == 2'b10 & |lo);
`else
   assign err = 1'b0;
`endif
   assign bus.cmd_ready    = state == IDLE;
   // In IDLE the RAM sees the incoming address so the old word is ready during ACCESS.
   assign ram_address      = state == IDLE ? bus.cmd_addr[ADDRESS_BITWIDTH+1:2] : wa;
   assign ram_write_enable = rst_n & (state == ACCESS) & wr & ~err;
   // sz[1] set means word (size 11 only reaches here as word when alignment checking is off).
   always_comb begin
      sh          = sz[0] ? {lo[1], 4'b0} : {lo, 3'b0};
      mask        = sz[1] ? '1 : (sz[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
      rep         = sz[1] ? wd : sz[0] ? {2{wd[15:0]}} : {4{wd[7:0]}};
      ram_data_in = (ram_data_out & ~mask) | (rep & mask);
      lane        = 16'(ram_data_out >> sh);
      ld          = sz[1] ? ram_data_out :
                    sz[0] ? {{16{sgn & lane[15]}}, lane} : {{24{sgn & lane[7]}}, lane[7:0]};
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_error <= 1'b0;
      end else if (state == IDLE) begin
         bus.rsp_valid <= 1'b0;
         if (bus.cmd_valid) begin
            wr    <= bus.cmd_write;
            sz    <= bus.cmd_size;
            sgn   <= bus.cmd_signed;
            lo    <= bus.cmd_addr[1:0];
            wa    <= bus.cmd_addr[ADDRESS_BITWIDTH+1:2];
            wd    <= bus.cmd_wdata;
            state <= ACCESS;
         end
      end else begin
         bus.rsp_valid <= 1'b1;
         bus.rsp_rdata <= (wr | err) ? '0 : ld;
         bus.rsp_error <= err;
         state         <= IDLE;
      end
   end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: randomized self-checking bench for ram_access_ctrl with a behavioural RAM
//   and a command-level reference memory. Honors RAM_ACCESS_ALIGN_CHECK_EN like the design.
module tb_ram_access_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   ram_access_ctrl_if #(.ADDRESS_BITWIDTH(16)) bus ();
   logic        ram_write_enable;
   logic [15:0] ram_address;
   logic [31:0] ram_data_in, ram_data_out;
   logic [31:0] ram [16];
   logic [31:0] ref_mem [16];
   int n_cmp = 0;
   int n_bad = 0;
`ifdef RAM_ACCESS_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif
   ram_access_ctrl #(.ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .ram_write_enable(ram_write_enable),
      .ram_address(ram_address),
      .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out)
   );
   // Single-port RAM with registered read; bench addresses stay in the first 16 words.
   always @(posedge clk) begin
      if (ram_write_enable) ram[ram_address[3:0]] <= ram_data_in;
      ram_data_out <= ram[ram_address[3:0]];
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
      end
   endtask
   function automatic logic err_of(input logic [1:0] sz, input logic [17:0] a);
      return ALIGN_CHK && (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0));
   endfunction
   function automatic logic [31:0] ld_val(input logic [31:0] word, input logic [1:0] sz,
                                           input logic sgn, input logic [17:0] a);
      logic [31:0] v;
      int b;
      b = int'(a % 4);
      if (sz == 2'd0) begin
         v = (word >> (8 * b)) % 256;
         if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (word >> (16 * (b / 2))) % 65536;
         if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
      end else v = word;
      return v;
   endfunction
   function automatic logic [31:0] st_val(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [17:0] a, input logic [31:0] wd);
      int sh;
      logic [31:0] old;
      if (sz == 2'd0) begin
         sh  = 8 * int'(a % 4);
         old = (word >> sh) % 256;
         return word - (old << sh) + ((wd % 256) << sh);
      end else if (sz == 2'd1) begin
         sh  = 16 * int'((a % 4) / 2);
         old = (word >> sh) % 65536;
         return word - (old << sh) + ((wd % 65536) << sh);
      end
      return wd;
   endfunction
   task automatic drive(input logic w, input logic [1:0] sz, input logic sgn,
                        input logic [17:0] a, input logic [31:0] wd);
      bus.cmd_valid  = 1'b1;
      bus.cmd_write  = w;
      bus.cmd_size   = sz;
      bus.cmd_signed = sgn;
      bus.cmd_addr   = a;
      bus.cmd_wdata  = wd;
   endtask
   task automatic do_cmd(input logic w, input logic [1:0] sz, input logic sgn,
                         input logic [17:0] a, input logic [31:0] wd, output logic [31:0] got);
      int idx;
      logic e, we;
      logic [31:0] nw, rd;
      idx = int'((a / 4) % 16);
      e   = err_of(sz, a);
      we  = w && !e;
      nw  = st_val(ref_mem[idx], sz, a, wd);
      rd  = (w || e) ? 32'h0 : ld_val(ref_mem[idx], sz, sgn, a);
      @(negedge clk);
      drive(w, sz, sgn, a, wd);
      #1;
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
      chk("idle_addr", 32'(ram_address), 32'(idx));
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      chk("acc_ready", 32'(bus.cmd_ready), 32'd0);
      chk("acc_we", 32'(ram_write_enable), 32'(we));
      chk("acc_addr", 32'(ram_address), 32'(idx));
      if (we) chk("acc_wdata", ram_data_in, nw);
      @(negedge clk);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_rdata", bus.rsp_rdata, rd);
      chk("rsp_error", 32'(bus.rsp_error), 32'(e));
      if (we) ref_mem[idx] = nw;
      chk("mem", ram[idx], ref_mem[idx]);
      got = bus.rsp_rdata;
   endtask
   initial begin
      logic [31:0] got, bw;
      logic [31:0] rdv [3];
      logic        cw [3];
      logic [1:0]  cs [3];
      logic        csg [3];
      logic [17:0] ca [3];
      int k;
      bus.cmd_valid  = 1'b0;
      bus.cmd_write  = 1'b0;
      bus.cmd_size   = 2'd0;
      bus.cmd_signed = 1'b0;
      bus.cmd_addr   = '0;
      bus.cmd_wdata  = '0;
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_we", 32'(ram_write_enable), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) do_cmd(1'b1, 2'd2, 1'b0, 18'(i * 4), $urandom, got);
      do_cmd(1'b1, 2'd2, 1'b0, 18'h10, 32'hDEADBEEF, got);
      do_cmd(1'b0, 2'd2, 1'b0, 18'h10, 32'h0, got);
      chk("tp_lw", got, 32'hDEADBEEF);
      do_cmd(1'b1, 2'd0, 1'b0, 18'h12, 32'h55, got);
      chk("tp_sb_word", ram[4], 32'hDE55BEEF);
      do_cmd(1'b0, 2'd0, 1'b1, 18'h13, 32'h0, got);
      chk("tp_lb_signed", got, 32'hFFFFFFDE);
      do_cmd(1'b0, 2'd0, 1'b0, 18'h13, 32'h0, got);
      chk("tp_lb_unsigned", got, 32'h000000DE);
      do_cmd(1'b1, 2'd2, 1'b0, 18'h14, 32'hAABBCCDD, got);
      do_cmd(1'b1, 2'd1, 1'b0, 18'h16, 32'h1234, got);
      chk("tp_sh_word", ram[5], 32'h1234CCDD);
      do_cmd(1'b0, 2'd1, 1'b1, 18'h14, 32'h0, got);
      chk("tp_lh_signed", got, 32'hFFFFCCDD);
      do_cmd(1'b1, 2'd2, 1'b0, 18'h11, 32'h11111111, got);
`ifdef RAM_ACCESS_ALIGN_CHECK_EN
      chk("tp_misaligned_sw", ram[4], 32'hDE55BEEF);
`else
      chk("tp_misaligned_sw", ram[4], 32'h11111111);
`endif
      // Back-to-back: store word, load it back, load a signed byte; cmd_valid held high.
      bw  = $urandom;
      cw  = '{1'b1, 1'b0, 1'b0};
      cs  = '{2'd2, 2'd2, 2'd0};
      csg = '{1'b0, 1'b0, 1'b1};
      ca  = '{18'h20, 18'h20, 18'h21};
      ref_mem[8] = bw;
      rdv = '{32'h0, bw, ld_val(bw, 2'd0, 1'b1, 18'h21)};
      k = 0;
      for (int cy = 0; cy < 7; cy++) begin
         @(negedge clk);
         if (cy % 2 == 0 && k < 3) begin
            drive(cw[k], cs[k], csg[k], ca[k], bw);
            k++;
         end else if (cy == 5) bus.cmd_valid = 1'b0;
         #1;
         chk("b2b_ready", 32'(bus.cmd_ready), 32'(cy % 2 == 0));
         chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'(cy >= 2 && cy % 2 == 0));
         if (cy >= 2 && cy % 2 == 0) chk("b2b_rdata", bus.rsp_rdata, rdv[cy / 2 - 1]);
         chk("b2b_we", 32'(ram_write_enable), 32'(cy == 1));
      end
      chk("b2b_mem", ram[8], ref_mem[8]);
      // Reset during the ACCESS cycle of a byte store.
      @(negedge clk);
      drive(1'b1, 2'd0, 1'b0, 18'h24, 32'h5A ^ ref_mem[9]);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_acc_we", 32'(ram_write_enable), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_acc_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("rst_acc_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_acc_mem", ram[9], ref_mem[9]);
      @(negedge clk);
      chk("rst_acc_rsp_late", 32'(bus.rsp_valid), 32'd0);
      for (int i = 0; i < 300; i++)
         do_cmd(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), 18'($urandom % 64), $urandom, got);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
